spi_slave: RTL and testbench

- SPI mode-0 slave (CPOL=0, CPHA=0), MSB first, 8-bit frames.
- SCK, MOSI and CS are external asynchronous inputs. They are synchronized into the system clock domain and edge-detected there.
- Each received byte is presented on mdata with a one-cycle valid strobe and a first-byte-of-transaction flag.
- Byte sdata is shifted out on miso concurrently; it is the host-facing bridge between an SPI master and on-chip registers.

---
 rtl/spi_slave_pkg.sv | 16 +
 rtl/spi_slave_if.sv | 27 ++
 rtl/spi_slave_sync_edge_detect.sv | 43 ++++
 rtl/spi_slave.sv | 137 +++++++++++++
 tb/tb_spi_slave.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/spi_slave_pkg.sv
// rtl/spi_slave_pkg.sv - shared constants for the SPI mode-0 slave
// Purpose: frame and bit-counter widths plus idle levels used by the
//          synchronizer reset values.
// Ports:   none (package)
package spi_slave_pkg;

  localparam int SPI_BYTE_W   = 8;
  localparam int SPI_BITCNT_W = 3;

  // Idle levels of the serial lines; synchronizers reset to these so no
  // spurious edge is seen when reset is released with the bus idle.
  localparam logic CS_IDLE   = 1'b1;
  localparam logic SCK_IDLE  = 1'b0;
  localparam logic MOSI_IDLE = 1'b0;

endpackage

// File: rtl/spi_slave_if.sv
// rtl/spi_slave_if.sv - SPI pins plus host-side byte interface
// Purpose: groups the serial lines and the received/transmit byte handshake.
// Ports:   slave modport  - mosi/sck/cs/sdata in, miso/mdata/data_valid_read/data_firstbyte out
//          master modport - mirror image, used by whoever drives the bus
interface spi_slave_if;
  import spi_slave_pkg::*;

  logic                  mosi;
  logic                  miso;
  logic                  sck;
  logic                  cs;
  logic [SPI_BYTE_W-1:0] mdata;
  logic [SPI_BYTE_W-1:0] sdata;
  logic                  data_valid_read;
  logic                  data_firstbyte;

  modport slave (
    input  mosi, sck, cs, sdata,
    output miso, mdata, data_valid_read, data_firstbyte
  );

  modport master (
    output mosi, sck, cs, sdata,
    input  miso, mdata, data_valid_read, data_firstbyte
  );

endinterface

// File: rtl/spi_slave_sync_edge_detect.sv
// rtl/spi_slave_sync_edge_detect.sv - input synchronizer with edge pulses
// Purpose: brings an asynchronous line into the clk domain through
//          SYNC_STAGES flops and flags rising/falling transitions.
// Ports:   clk, rst    - system clock, async active-high reset
//          async_i     - asynchronous input line
//          rise_o      - one-clk pulse on a synchronized 0->1 transition
//          fall_o      - one-clk pulse on a synchronized 1->0 transition
module spi_slave_sync_edge_detect #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] chain_q, chain_d;
  logic                   prev_q, prev_d;
  logic                   level;

  assign level = chain_q[SYNC_STAGES-1];

  always_comb begin
    chain_d = {chain_q[SYNC_STAGES-2:0], async_i};
    prev_d  = level;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q  <= RESET_VAL;
    end else begin
      chain_q <= chain_d;
      prev_q  <= prev_d;
    end
  end

  assign rise_o = level & ~prev_q;
  assign fall_o = ~level & prev_q;

endmodule

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - SPI mode-0 slave, MSB first, 8-bit frames
// Purpose: oversamples sck/cs/mosi in the clk domain, assembles received
//          bytes for the host and shifts sdata back out on miso.
// Ports:   clk, rst              - system clock, async active-high reset
//          bus (slave modport)   - mosi/sck/cs serial inputs, miso output,
//                                  mdata/data_valid_read/data_firstbyte to host,
//                                  sdata from host (sampled at byte boundaries)
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  spi_slave_if.slave bus
);

  logic sck_rise, sck_fall;
  logic cs_rise, cs_fall;

  spi_slave_sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (SCK_IDLE)
  ) u_sck_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (bus.sck),
    .rise_o  (sck_rise),
    .fall_o  (sck_fall)
  );

  spi_slave_sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (CS_IDLE)
  ) u_cs_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (bus.cs),
    .rise_o  (cs_rise),
    .fall_o  (cs_fall)
  );

  // mosi needs the same depth as sck so the sampled bit lines up with the
  // detected rising edge; no edge detection required.
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   mosi_sync;

  assign mosi_sync = mosi_sync_q[SYNC_STAGES-1];

  logic                    cs_active_q, cs_active_d;
  logic [SPI_BITCNT_W-1:0] cnt_q, cnt_d;
  logic [SPI_BYTE_W-1:0]   rx_q, rx_d;
  logic [SPI_BYTE_W-1:0]   tx_q, tx_d;
  logic                    first_q, first_d;
  logic                    done_q, done_d;
  logic [SPI_BYTE_W-1:0]   mdata_q, mdata_d;
  logic                    valid_q, valid_d;
  logic                    firstbyte_q, firstbyte_d;

  always_comb begin
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
    cs_active_d = cs_active_q;
    cnt_d       = cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    first_d     = first_q;
    done_d      = 1'b0;
    mdata_d     = mdata_q;
    valid_d     = 1'b0;
    firstbyte_d = firstbyte_q;

    // Hand the byte completed last cycle to the host and fetch the next one
    // to transmit; the following sck fall sees cnt==0 and keeps its MSB.
    if (done_q) begin
      mdata_d     = rx_q;
      valid_d     = 1'b1;
      firstbyte_d = first_q;
      first_d     = 1'b0;
      tx_d        = bus.sdata;
    end

    // cs fall wins over any sck edge seen in the same cycle.
    if (cs_fall) begin
      cs_active_d = 1'b1;
      cnt_d       = '0;
      first_d     = 1'b1;
      tx_d        = bus.sdata;
    end else if (cs_rise) begin
      // Partial byte is dropped; the next selection restarts at bit 0.
      cs_active_d = 1'b0;
      cnt_d       = '0;
      rx_d        = '0;
    end else if (cs_active_q) begin
      if (sck_rise) begin
        rx_d  = {rx_q[SPI_BYTE_W-2:0], mosi_sync};
        cnt_d = cnt_q + SPI_BITCNT_W'(1);
        if (cnt_q == SPI_BITCNT_W'(SPI_BYTE_W - 1)) begin
          done_d = 1'b1;
        end
      end else if (sck_fall && (cnt_q != '0)) begin
        tx_d = {tx_q[SPI_BYTE_W-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mosi_sync_q <= {SYNC_STAGES{MOSI_IDLE}};
      cs_active_q <= 1'b0;
      cnt_q       <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      first_q     <= 1'b1;
      done_q      <= 1'b0;
      mdata_q     <= '0;
      valid_q     <= 1'b0;
      firstbyte_q <= 1'b0;
    end else begin
      mosi_sync_q <= mosi_sync_d;
      cs_active_q <= cs_active_d;
      cnt_q       <= cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      first_q     <= first_d;
      done_q      <= done_d;
      mdata_q     <= mdata_d;
      valid_q     <= valid_d;
      firstbyte_q <= firstbyte_d;
    end
  end

  assign bus.miso            = cs_active_q & tx_q[SPI_BYTE_W-1];
  assign bus.mdata           = mdata_q;
  assign bus.data_valid_read = valid_q;
  assign bus.data_firstbyte  = firstbyte_q;

endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - self-checking bench for spi_slave
module tb_spi_slave;

  localparam int H = 6;  // sck half-period in clk cycles

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   pulses;

  logic [8:0] sb_q[$];  // {firstbyte, mdata} expected per pulse

  spi_slave_if bus();

  spi_slave #(.SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.data_valid_read === 1'b1) begin
      pulses++;
      if (sb_q.size() == 0) begin
        check("unexpected_pulse", 32'(bus.mdata), 32'hffff_ffff);
      end else begin
        logic [8:0] e;
        e = sb_q.pop_front();
        check("mdata", 32'(bus.mdata), 32'(e[7:0]));
        check("firstbyte", 32'(bus.data_firstbyte), 32'(e[8]));
      end
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Master side: sends the top n bits of b, returns what it sampled on miso
  // at each sck rise (left-aligned).
  task automatic spi_bits(input logic [7:0] b, input int n, output logic [7:0] r);
    r = '0;
    for (int i = 7; i > 7 - n; i--) begin
      bus.mosi = b[i];
      wait_clks(H);
      r[i] = bus.miso;
      bus.sck = 1'b1;
      wait_clks(H);
      bus.sck = 1'b0;
    end
    wait_clks(H);
  endtask

  task automatic spi_byte(input logic [7:0] b, input logic first, output logic [7:0] r);
    sb_q.push_back({first, b});
    spi_bits(b, 8, r);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] r;
    int         p0;
    total = 0;
    bad = 0;
    pulses = 0;

    rst = 1'b1;
    bus.sdata = 8'h8a;
    bus.cs = 1'b1;
    bus.sck = 1'b0;
    bus.mosi = 1'b0;
    wait_clks(3);
    @(negedge clk);
    check("rst_mdata", 32'(bus.mdata), 32'h00);
    check("rst_valid", 32'(bus.data_valid_read), 32'h0);
    check("rst_firstbyte", 32'(bus.data_firstbyte), 32'h0);
    check("rst_miso", 32'(bus.miso), 32'h0);
    wait_clks(1);
    rst = 1'b0;
    wait_clks(4);

    // Two bytes in one selection.
    bus.cs = 1'b0;
    wait_clks(H);
    spi_byte(8'hA5, 1'b1, r);
    check("miso_byte1", 32'(r), 32'h8a);
    spi_byte(8'h3C, 1'b0, r);
    check("miso_byte2", 32'(r), 32'h8a);
    check("pulses_after_2", 32'(pulses), 32'd2);
    bus.cs = 1'b1;
    wait_clks(H);

    // Aborted partial byte, then a full byte in a fresh selection.
    bus.cs = 1'b0;
    wait_clks(H);
    spi_bits(8'hF0, 4, r);
    bus.cs = 1'b1;
    bus.sdata = 8'h5c;
    wait_clks(2 * H);
    check("pulses_after_abort", 32'(pulses), 32'd2);
    bus.cs = 1'b0;
    wait_clks(H);
    spi_byte(8'hFF, 1'b1, r);
    check("miso_byte3", 32'(r), 32'h5c);
    check("pulses_after_ff", 32'(pulses), 32'd3);
    bus.cs = 1'b1;
    wait_clks(H);

    // sck activity while deselected is ignored.
    p0 = pulses;
    for (int i = 0; i < 10; i++) begin
      bus.mosi = 1'($urandom_range(0, 1));
      bus.sck = ~bus.sck;
      wait_clks(H);
      check("miso_cs_high", 32'(bus.miso), 32'h0);
    end
    bus.sck = 1'b0;
    wait_clks(H);
    check("pulses_cs_high", 32'(pulses), 32'(p0));
    check("mdata_held", 32'(bus.mdata), 32'hFF);
    check("firstbyte_held", 32'(bus.data_firstbyte), 32'h1);

    // Reset in the middle of a byte.
    bus.cs = 1'b0;
    wait_clks(H);
    spi_bits(8'hAA, 3, r);
    rst = 1'b1;
    bus.sck = 1'b0;
    wait_clks(3);
    @(negedge clk);
    check("midrst_mdata", 32'(bus.mdata), 32'h00);
    check("midrst_valid", 32'(bus.data_valid_read), 32'h0);
    check("midrst_miso", 32'(bus.miso), 32'h0);
    wait_clks(1);
    rst = 1'b0;
    wait_clks(2 * H);
    spi_byte(8'h01, 1'b1, r);
    check("miso_byte4", 32'(r), 32'h5c);
    check("pulses_final", 32'(pulses), 32'd4);
    bus.cs = 1'b1;
    wait_clks(H);
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
